// File: rtl/reservation_station_if.sv
// Reservation station decoder / CDB / dispatch bundle.
// master drives decoder, CDB and rollback; slave is the station.
interface reservation_station_if #(
  parameter int ROB_W = 4,
  parameter int OP_W  = 6
);
  logic [ROB_W-1:0] in_decoder_rob_tag;
  logic [OP_W-1:0]  in_decoder_op;
  logic [31:0]      in_decoder_value1;
  logic [31:0]      in_decoder_value2;
  logic [ROB_W-1:0] in_decoder_tag1;
  logic [ROB_W-1:0] in_decoder_tag2;
  logic [31:0]      in_decoder_imm;
  logic [31:0]      in_decoder_pc;
  logic [ROB_W-1:0] in_alu_cdb_tag;
  logic [31:0]      in_alu_cdb_value;
  logic [ROB_W-1:0] in_lsb_cdb_tag;
  logic [31:0]      in_lsb_cdb_value;
  logic             in_rob_rollback;
  logic             out_full;
  logic [ROB_W-1:0] out_alu_rob_tag;
  logic [OP_W-1:0]  out_alu_op;
  logic [31:0]      out_alu_value1;
  logic [31:0]      out_alu_value2;
  logic [31:0]      out_alu_imm;
  logic [31:0]      out_alu_pc;

  modport master (
    output in_decoder_rob_tag, in_decoder_op,
    output in_decoder_value1, in_decoder_value2,
    output in_decoder_tag1, in_decoder_tag2,
    output in_decoder_imm, in_decoder_pc,
    output in_alu_cdb_tag, in_alu_cdb_value,
    output in_lsb_cdb_tag, in_lsb_cdb_value,
    output in_rob_rollback,
    input  out_full, out_alu_rob_tag, out_alu_op,
    input  out_alu_value1, out_alu_value2,
    input  out_alu_imm, out_alu_pc
  );

  modport slave (
    input  in_decoder_rob_tag, in_decoder_op,
    input  in_decoder_value1, in_decoder_value2,
    input  in_decoder_tag1, in_decoder_tag2,
    input  in_decoder_imm, in_decoder_pc,
    input  in_alu_cdb_tag, in_alu_cdb_value,
    input  in_lsb_cdb_tag, in_lsb_cdb_value,
    input  in_rob_rollback,
    output out_full, out_alu_rob_tag, out_alu_op,
    output out_alu_value1, out_alu_value2,
    output out_alu_imm, out_alu_pc
  );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: allocate, CDB wakeup, in-order-by-slot dispatch.
// Ports: clk, rst (async active-low), rdy (enable), bus (slave modport).
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 rdy,
  reservation_station_if.slave bus
);
  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef logic [ROB_W-1:0] tag_t;

  typedef struct packed {
    logic            busy;
    tag_t            tag;
    logic [OP_W-1:0] op;
    tag_t            t1;
    logic [31:0]     v1;
    tag_t            t2;
    logic [31:0]     v2;
    logic [31:0]     imm;
    logic [31:0]     pc;
  } ent_t;

  ent_t            ent_q [RS_SIZE];
  ent_t            new_ent;
  logic [RS_SIZE-1:0] busy_v;
  logic            dsp_hit;
  logic [IW-1:0]   dsp_idx;
  logic            free_hit;
  logic [IW-1:0]   free_idx;
  logic            alloc;

  tag_t            o_tag;
  logic [OP_W-1:0] o_op;
  logic [31:0]     o_v1;
  logic [31:0]     o_v2;
  logic [31:0]     o_imm;
  logic [31:0]     o_pc;

  // ALU broadcast takes priority over LSB on a shared tag.
  function automatic logic [ROB_W+31:0] snoop(
    input tag_t t, input logic [31:0] v
  );
    if (t != '0 && t == bus.in_alu_cdb_tag)
      return {{ROB_W{1'b0}}, bus.in_alu_cdb_value};
    else if (t != '0 && t == bus.in_lsb_cdb_tag)
      return {{ROB_W{1'b0}}, bus.in_lsb_cdb_value};
    else
      return {t, v};
  endfunction

  // Descending scan so the lowest index wins.
  always_comb begin
    busy_v   = '0;
    dsp_hit  = 1'b0;
    dsp_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      busy_v[i] = ent_q[i].busy;
      if (ent_q[i].busy && ent_q[i].t1 == '0
          && ent_q[i].t2 == '0) begin
        dsp_hit = 1'b1;
        dsp_idx = IW'(i);
      end
      if (!ent_q[i].busy) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    new_ent      = '0;
    new_ent.busy = 1'b1;
    new_ent.tag  = bus.in_decoder_rob_tag;
    new_ent.op   = bus.in_decoder_op;
    new_ent.imm  = bus.in_decoder_imm;
    new_ent.pc   = bus.in_decoder_pc;
    {new_ent.t1, new_ent.v1} =
      snoop(bus.in_decoder_tag1, bus.in_decoder_value1);
    {new_ent.t2, new_ent.v2} =
      snoop(bus.in_decoder_tag2, bus.in_decoder_value2);
  end

  // free_hit is pre-edge, so a slot dispatched this edge is not reused.
  assign alloc = (bus.in_decoder_rob_tag != '0) && free_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      o_tag <= '0;
      o_op  <= '0;
      o_v1  <= '0;
      o_v2  <= '0;
      o_imm <= '0;
      o_pc  <= '0;
    end else if (!rdy) begin
      o_tag <= '0;
    end else begin
      o_tag <= '0;
      o_op  <= '0;
      o_v1  <= '0;
      o_v2  <= '0;
      o_imm <= '0;
      o_pc  <= '0;
      if (bus.in_rob_rollback) begin
        for (int i = 0; i < RS_SIZE; i++)
          ent_q[i].busy <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent_q[i].busy) begin
            {ent_q[i].t1, ent_q[i].v1} <=
              snoop(ent_q[i].t1, ent_q[i].v1);
            {ent_q[i].t2, ent_q[i].v2} <=
              snoop(ent_q[i].t2, ent_q[i].v2);
          end
        end
        if (dsp_hit) begin
          ent_q[dsp_idx].busy <= 1'b0;
          o_tag <= ent_q[dsp_idx].tag;
          o_op  <= ent_q[dsp_idx].op;
          o_v1  <= ent_q[dsp_idx].v1;
          o_v2  <= ent_q[dsp_idx].v2;
          o_imm <= ent_q[dsp_idx].imm;
          o_pc  <= ent_q[dsp_idx].pc;
        end
        if (alloc) ent_q[free_idx] <= new_ent;
      end
    end
  end

  assign bus.out_full        = &busy_v;
  assign bus.out_alu_rob_tag = o_tag;
  assign bus.out_alu_op      = o_op;
  assign bus.out_alu_value1  = o_v1;
  assign bus.out_alu_value2  = o_v2;
  assign bus.out_alu_imm     = o_imm;
  assign bus.out_alu_pc      = o_pc;
endmodule
